regfile_wb_ctrl: RTL
====================

// Module: regfile_wb_ctrl
// PURPOSE
//  Write-side controller for the 32x32 regfile write port (we/writeaddr/writedata).
//  Merges two producers: the in-order pipeline writeback (fixed slot, no backpressure)
//  and a multicycle unit (divider/load) with valid/ready handshake, buffered in a FIFO.
//  Tracks pending FIFO writes per register for the hazard unit. Enforces WAW ordering.
//  Prevents starvation of the multicycle unit.
// PARAMETERS
//  DEPTH       4  multicycle result FIFO entries; power of 2, >=2
//  STARVE_MAX  8  consecutive blocked cycles before stall_o asserts; >=1
// PORTS
//  clk        in   1                 clock, all state on posedge
//  rst        in   1                 synchronous reset, active-high
//  p_valid    in   1                 pipeline writeback valid this cycle
//  p_addr     in   5                 pipeline destination register
//  p_data     in   32                pipeline write data
//  m_valid    in   1                 multicycle result valid
//  m_ready    out  1                 FIFO accepts the m_* beat
//  m_addr     in   5                 multicycle destination register
//  m_data     in   32                multicycle result data
//  rf_we      out  1                 to regfile we
//  rf_waddr   out  5                 to regfile writeaddr
//  rf_wdata   out  32                to regfile writedata
//  busy_mask  out  32                bit i=1: live FIFO entry targets reg i
//  stall_o    out  1                 request that pipeline hold p_valid low
//  fifo_count out  $clog2(DEPTH)+1   entries held (live + killed)
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO empty; all kill flags 0; starve counter 0; stall_o=0.
//   While rst=1: m_ready=0, rf_we=0. Reset mid-operation discards all entries.
//  Handshake: m_ready = ~rst & (fifo_count<DEPTH). It depends only on FIFO fullness.
//   Push on m_valid&m_ready. A full FIFO does not accept a push even when it pops the same cycle.
//  x0: p_valid with p_addr==0 gives rf_we=0. An m beat with m_addr==0 is accepted (ready honoured)
//   and discarded, not enqueued.
//  Write-port select (combinational, 0-cycle latency from inputs/FIFO head):
//   1) p_valid & p_addr!=0    -> rf_we=1, rf_waddr=p_addr, rf_wdata=p_data (pipeline always wins)
//   2) else head live         -> rf_we=1, head addr/data; pop head
//   3) else                   -> rf_we=0; rf_waddr/rf_wdata=0
//  Killed head: popped the same cycle without a write, independent of p_valid. At most 1 pop/cycle.
//  Pushed entry is never written the cycle it is pushed. Minimum m-to-rf latency is 1 cycle.
//  WAW kill: a multicycle result is always older than a concurrent or later pipeline write.
//   A pipeline write to A!=0 sets the kill flag on every FIFO entry with addr A.
//   This includes an entry being pushed in that same cycle.
//  busy_mask: OR of one-hot(addr) over FIFO entries that are not killed. It comes from registered state.
//   Bits set the cycle after push and clear the cycle after pop/kill. Bit 0 is always 0.
//  Starvation: counter increments on each cycle with a live head and p_valid=1 (no pop).
//   The counter clears on any pop or when the FIFO is empty. It saturates at STARVE_MAX.
//   stall_o is registered. It goes to 1 the cycle after the counter reaches STARVE_MAX.
//   It stays 1 until the cycle after a live-head write pop.
//   If the pipeline ignores stall_o, rule 1 still holds and no data is lost.
//  fifo_count: registered occupancy, 0..DEPTH. Pointers wrap modulo DEPTH.
// TESTING
//  T1 reset: rst=1 for 2 cycles with m_valid=1 -> m_ready=0, rf_we=0, busy_mask=0, fifo_count=0.
//  T2 drain: push m(addr 5, 0xDEAD_BEEF), p_valid=0 -> next cycle rf_we=1/5/0xDEADBEEF;
//     busy_mask[5] 1 for exactly 1 cycle.
//  T3 full: DEPTH pushes while p_valid=1 (addrs 1..4) -> m_ready=0 at count 4;
//     first p_valid=0 cycle pops addr 1, in FIFO order.
//  T4 WAW: FIFO holds addr 7; p write addr 7 (0x11) -> entry killed, busy_mask[7]=0 next cycle;
//     popped with rf_we=0; reg7 keeps 0x11. Repeat with push and p write to 7 in the same cycle.
//  T5 x0: p_addr=0, p_valid=1 -> rf_we=0. m_addr=0 accepted -> fifo_count unchanged, no write.
//  T6 starve: live head + p_valid=1 for STARVE_MAX cycles -> stall_o=1 next cycle.
//     Drop p_valid -> head written, stall_o=0 the cycle after.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the 32x32 regfile: merges pipeline writeback with a
// FIFO-buffered multicycle result stream, with WAW kill and starvation stall.
module regfile_wb_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p_valid,
    input  logic [4:0]                 p_addr,
    input  logic [31:0]                p_data,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [4:0]                 m_addr,
    input  logic [31:0]                m_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [31:0]                busy_mask,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_kill;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic             p_wr;
    logic             head_valid;
    logic             head_live;
    logic             pop;
    logic             live_pop;
    logic             push;
    logic             push_kill;
    logic [SW-1:0]    starve_nxt;
    logic             stall_nxt;

    // Write-port arbitration: pipeline first, then a live FIFO head.
    always_comb begin
        p_wr       = p_valid && (p_addr != 5'd0);
        head_valid = ent_valid[rd_ptr];
        head_live  = head_valid && !ent_kill[rd_ptr];
        m_ready    = !rst && (count < CW'(DEPTH));
        push       = m_valid && m_ready && (m_addr != 5'd0);
        push_kill  = p_wr && (p_addr == m_addr);
        rf_we      = 1'b0;
        rf_waddr   = 5'd0;
        rf_wdata   = 32'd0;
        pop        = 1'b0;
        live_pop   = 1'b0;
        if (!rst) begin
            if (p_wr) begin
                rf_we    = 1'b1;
                rf_waddr = p_addr;
                rf_wdata = p_data;
            end else if (head_live) begin
                rf_we    = 1'b1;
                rf_waddr = ent_addr[rd_ptr];
                rf_wdata = ent_data[rd_ptr];
                live_pop = 1'b1;
            end
            // A killed head leaves regardless of the pipeline slot.
            pop = live_pop || (head_valid && !head_live);
        end
    end

    // Starvation counter and stall request next state.
    always_comb begin
        starve_nxt = starve_cnt;
        stall_nxt  = stall_o;
        if (pop || !head_valid) begin
            starve_nxt = '0;
        end else if (head_live && p_wr && (starve_cnt < SW'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + SW'(1);
        end
        if (live_pop) begin
            stall_nxt = 1'b0;
        end else if (starve_nxt == SW'(STARVE_MAX)) begin
            stall_nxt = 1'b1;
        end
    end

    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_valid[i] && !ent_kill[i]) begin
                busy_mask[ent_addr[i]] = 1'b1;
            end
        end
    end

    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid  <= '0;
            ent_kill   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_o    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (p_wr && (ent_addr[i] == p_addr)) begin
                    ent_kill[i] <= 1'b1;
                end
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + AW'(1);
            end
            // Push never targets the popped slot: a full FIFO refuses pushes.
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_kill[wr_ptr]  <= push_kill;
                ent_addr[wr_ptr]  <= m_addr;
                ent_data[wr_ptr]  <= m_data;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            count      <= count + CW'(push) - CW'(pop);
            starve_cnt <= starve_nxt;
            stall_o    <= stall_nxt;
        end
    end

endmodule
